// File: rtl/query_patch_ram_wb.sv
// Dual-port patch store (A: rd/wr, B: rd) plus Wishbone slave; port reads and WB write ack 1 cycle, WB read ack 2 cycles.
// No backpressure: WB is held off by the ack FSM (busy); a cyc/wb_mode drop aborts silently.
module query_patch_ram_wb #(
    parameter int          DATA_WIDTH = 11,
    parameter int          PATCH_SIZE = 5,
    parameter int          ADDR_WIDTH = 9,
    parameter int          DEPTH      = 512,
    parameter logic [31:0] WB_BASE    = 32'h3000_0000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             csb0,
    input  logic                             web0,
    input  logic [ADDR_WIDTH-1:0]            addr0,
    input  logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
    output logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch0,
    input  logic                             csb1,
    input  logic [ADDR_WIDTH-1:0]            addr1,
    output logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch1,
    input  logic                             wb_mode,
    input  logic                             wbs_stb_i,
    input  logic                             wbs_cyc_i,
    input  logic                             wbs_we_i,
    input  logic [3:0]                       wbs_sel_i,
    input  logic [31:0]                      wbs_adr_i,
    input  logic [31:0]                      wbs_dat_i,
    output logic                             wbs_ack_o,
    output logic [31:0]                      wbs_dat_o,
    output logic                             wb_busy
);
    localparam int          W        = DATA_WIDTH * PATCH_SIZE;
    localparam int          NW       = (W + 31) / 32;
    localparam int          WSB      = $clog2(NW);
    localparam int          WSBW     = (WSB > 0) ? WSB : 1;
    localparam int          PW       = 32 * (2 ** WSB);
    localparam logic [31:0] WB_LIMIT = 32'(DEPTH * NW * 4);

    typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK} state_t;

    logic [W-1:0] mem [DEPTH];

    state_t                state;
    logic [W-1:0]          rd_entry_q;
    logic [WSBW-1:0]       word_q;
    logic                  oor_q;

    logic [31:0]           wb_off;
    logic [ADDR_WIDTH-1:0] wb_entry;
    logic [WSBW-1:0]       wb_word;
    logic                  wb_oor;
    logic                  wb_req;
    logic                  wb_accept;
    logic                  wb_abort;
    logic [W-1:0]          wb_wdat;
    logic [W-1:0]          wb_bmask;
    logic [PW-1:0]         rd_pad;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [W-1:0]          wr_dat;
    logic [W-1:0]          wr_mask;

    assign wb_off    = wbs_adr_i - WB_BASE;
    assign wb_entry  = wb_off[2+WSB +: ADDR_WIDTH];
    assign wb_word   = (WSB > 0) ? wb_off[2 +: WSBW] : '0;
    assign wb_oor    = (wb_off >= WB_LIMIT) || (wb_off[1:0] != 2'b00);
    assign wb_req    = wb_mode & wbs_cyc_i & wbs_stb_i;
    assign wb_accept = (state == IDLE) && wb_req;
    assign wb_abort  = ~wb_mode | ~wbs_cyc_i;
    assign rd_pad    = PW'(rd_entry_q);

    // Bits at or above W have no storage, so the mask simply never reaches them.
    always_comb begin
        wb_wdat  = '0;
        wb_bmask = '0;
        for (int i = 0; i < W; i++) begin
            wb_wdat[i]  = wbs_dat_i[i % 32];
            wb_bmask[i] = ((i / 32) == int'(wb_word)) && wbs_sel_i[(i % 32) / 8];
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr0;
        wr_dat  = wpatch0;
        wr_mask = '1;
        if (wb_mode) begin
            wr_en   = wb_accept & wbs_we_i & ~wb_oor;
            wr_addr = wb_entry;
            wr_dat  = wb_wdat;
            wr_mask = wb_bmask;
        end else begin
            wr_en   = ~csb0 & ~web0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < W; i++) begin
                if (wr_mask[i]) mem[wr_addr][i] <= wr_dat[i];
            end
        end
    end

    // Reads sample mem before this edge's write lands, giving old data on collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpatch0    <= '0;
            rpatch1    <= '0;
            state      <= IDLE;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            wb_busy    <= 1'b0;
            rd_entry_q <= '0;
            word_q     <= '0;
            oor_q      <= 1'b0;
        end else begin
            if (!wb_mode && !csb0 && web0) rpatch0 <= mem[addr0];
            if (!csb1) rpatch1 <= mem[addr1];

            case (state)
                IDLE: begin
                    wbs_ack_o <= 1'b0;
                    if (wb_req) begin
                        word_q  <= wb_word;
                        oor_q   <= wb_oor;
                        wb_busy <= 1'b1;
                        if (wbs_we_i) begin
                            state     <= WR_ACK;
                            wbs_ack_o <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                            if (!wb_oor) rd_entry_q <= mem[wb_entry];
                        end
                    end
                end
                RD_WAIT: begin
                    if (wb_abort) begin
                        state   <= IDLE;
                        wb_busy <= 1'b0;
                    end else begin
                        state     <= RD_ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= oor_q ? 32'h0 : rd_pad[32*word_q +: 32];
                    end
                end
                default: begin
                    state     <= IDLE;
                    wbs_ack_o <= 1'b0;
                    wb_busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule
